// File: rtl/idu_ins_rx.sv
// Purpose: IFU->IDU receive buffer; splits RV32 fields for decode and parks the front end in WFI.
// Latency: a beat accepted at edge N is presented on idu_dec_* in cycle N+1.
// Backpressure: idu_ifu_rdy drops when the FIFO is full or in WFI; the head holds while idu_dec_rdy is low.
module idu_ins_rx #(
  parameter int          DEPTH   = 2,
  parameter int          PTR_W   = 1,
  parameter logic [31:0] WFI_ENC = 32'h10500073
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_vld,
  input  logic        alu_ifu_br_vld,
  input  logic        wake_vld,
  input  logic        ifu_idu_vld,
  input  logic [31:0] ifu_idu_ins,
  input  logic [31:0] ifu_idu_pc,
  output logic        idu_ifu_rdy,
  output logic        idu_ifu_wfi,
  output logic        idu_dec_vld,
  input  logic        idu_dec_rdy,
  output logic [31:0] idu_dec_ins,
  output logic [31:0] idu_dec_pc,
  output logic [6:0]  idu_dec_opcode,
  output logic [4:0]  idu_dec_rd,
  output logic [2:0]  idu_dec_funct3,
  output logic [4:0]  idu_dec_rs1,
  output logic [4:0]  idu_dec_rs2,
  output logic [6:0]  idu_dec_funct7
);

  localparam logic [0:0]     ST_RUN   = 1'b0;
  localparam logic [0:0]     ST_WFI   = 1'b1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [0:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      ins_mem [DEPTH];
  logic [31:0]      pc_mem  [DEPTH];

  logic flush;
  logic acc;
  logic is_wfi;
  logic push;
  logic pop;

  // Redirect or start discards everything buffered and anything arriving this cycle.
  assign flush       = start_vld | alu_ifu_br_vld;
  // Ready depends only on registered state, so there is no vld->rdy combinational path.
  assign idu_ifu_rdy = (state == ST_RUN) && (count != FULL_CNT);
  assign acc         = ifu_idu_vld & idu_ifu_rdy & ~flush;
  assign is_wfi      = (ifu_idu_ins == WFI_ENC);
  // WFI is consumed here and never reaches the decoder.
  assign push        = acc & ~is_wfi;
  assign idu_dec_vld = (count != '0);
  assign pop         = idu_dec_vld & idu_dec_rdy & ~flush;
  assign idu_ifu_wfi = (state == ST_WFI);

  assign idu_dec_ins    = ins_mem[rd_ptr];
  assign idu_dec_pc     = pc_mem[rd_ptr];
  assign idu_dec_opcode = idu_dec_ins[6:0];
  assign idu_dec_rd     = idu_dec_ins[11:7];
  assign idu_dec_funct3 = idu_dec_ins[14:12];
  assign idu_dec_rs1    = idu_dec_ins[19:15];
  assign idu_dec_rs2    = idu_dec_ins[24:20];
  assign idu_dec_funct7 = idu_dec_ins[31:25];

  // RUN/WFI control: flush beats wake, wake beats a new WFI (wake only counts while already asleep).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (flush) begin
      state <= ST_RUN;
    end else if ((state == ST_WFI) && wake_vld) begin
      state <= ST_RUN;
    end else if (acc && is_wfi) begin
      state <= ST_WFI;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is data-only and deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[wr_ptr] <= ifu_idu_ins;
      pc_mem[wr_ptr]  <= ifu_idu_pc;
    end
  end

endmodule

// File: tb/tb_idu_ins_rx.sv
// Bench for idu_ins_rx: directed vector table, async-reset sequence, and a random run
// against a queue-based reference model.
module tb_idu_ins_rx;

  localparam int          DEPTH = 2;
  localparam logic [31:0] WFI   = 32'h10500073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_vld, alu_ifu_br_vld, wake_vld, ifu_idu_vld, idu_dec_rdy;
  logic [31:0] ifu_idu_ins, ifu_idu_pc;
  logic        idu_ifu_rdy, idu_ifu_wfi, idu_dec_vld;
  logic [31:0] idu_dec_ins, idu_dec_pc;
  logic [6:0]  idu_dec_opcode, idu_dec_funct7;
  logic [4:0]  idu_dec_rd, idu_dec_rs1, idu_dec_rs2;
  logic [2:0]  idu_dec_funct3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idu_ins_rx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_vld      (start_vld),
    .alu_ifu_br_vld (alu_ifu_br_vld),
    .wake_vld       (wake_vld),
    .ifu_idu_vld    (ifu_idu_vld),
    .ifu_idu_ins    (ifu_idu_ins),
    .ifu_idu_pc     (ifu_idu_pc),
    .idu_ifu_rdy    (idu_ifu_rdy),
    .idu_ifu_wfi    (idu_ifu_wfi),
    .idu_dec_vld    (idu_dec_vld),
    .idu_dec_rdy    (idu_dec_rdy),
    .idu_dec_ins    (idu_dec_ins),
    .idu_dec_pc     (idu_dec_pc),
    .idu_dec_opcode (idu_dec_opcode),
    .idu_dec_rd     (idu_dec_rd),
    .idu_dec_funct3 (idu_dec_funct3),
    .idu_dec_rs1    (idu_dec_rs1),
    .idu_dec_rs2    (idu_dec_rs2),
    .idu_dec_funct7 (idu_dec_funct7)
  );

  typedef struct {
    logic        start, br, wake, vld;
    logic [31:0] ins, pc;
    logic        drdy;
    logic        e_rdy, e_wfi, e_vld;
    logic [31:0] e_ins, e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] ins, pc;
  } ent_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compares every output; head fields only when a head is expected.
  task automatic chk_all(input string tag, input logic e_rdy, input logic e_wfi,
                         input logic e_vld, input logic [31:0] e_ins, input logic [31:0] e_pc);
    chk({tag, ".rdy"}, 32'(idu_ifu_rdy), 32'(e_rdy));
    chk({tag, ".wfi"}, 32'(idu_ifu_wfi), 32'(e_wfi));
    chk({tag, ".vld"}, 32'(idu_dec_vld), 32'(e_vld));
    if (e_vld) begin
      chk({tag, ".ins"},    idu_dec_ins, e_ins);
      chk({tag, ".pc"},     idu_dec_pc,  e_pc);
      chk({tag, ".opcode"}, 32'(idu_dec_opcode), 32'(e_ins[6:0]));
      chk({tag, ".rd"},     32'(idu_dec_rd),     32'(e_ins[11:7]));
      chk({tag, ".funct3"}, 32'(idu_dec_funct3), 32'(e_ins[14:12]));
      chk({tag, ".rs1"},    32'(idu_dec_rs1),    32'(e_ins[19:15]));
      chk({tag, ".rs2"},    32'(idu_dec_rs2),    32'(e_ins[24:20]));
      chk({tag, ".funct7"}, 32'(idu_dec_funct7), 32'(e_ins[31:25]));
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic wk, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc, input logic dr);
    start_vld      = st;
    alu_ifu_br_vld = br;
    wake_vld       = wk;
    ifu_idu_vld    = v;
    ifu_idu_ins    = ins;
    ifu_idu_pc     = pc;
    idu_dec_rdy    = dr;
  endtask

  vec_t tbl [24];
  ent_t q[$];
  logic m_wfi;

  initial begin
    // start, br, wake, vld, ins, pc, drdy  ->  rdy, wfi, vld, head ins, head pc (after the edge)
    tbl[0]  = '{0,0,0,1,32'h00500093,32'h00,1, 1,0,1,32'h00500093,32'h00};
    tbl[1]  = '{0,0,0,1,32'h00a00113,32'h04,1, 1,0,1,32'h00a00113,32'h04};
    tbl[2]  = '{0,0,0,0,32'h0,32'h0,1,         1,0,0,32'h0,32'h0};
    tbl[3]  = '{0,0,0,1,32'h00100093,32'h00,0, 1,0,1,32'h00100093,32'h00};
    tbl[4]  = '{0,0,0,1,32'h00200113,32'h04,0, 0,0,1,32'h00100093,32'h00};
    tbl[5]  = '{0,0,0,1,32'h00300193,32'h08,0, 0,0,1,32'h00100093,32'h00};
    tbl[6]  = '{0,0,0,1,32'h00300193,32'h08,1, 1,0,1,32'h00200113,32'h04};
    tbl[7]  = '{0,0,0,1,32'h00300193,32'h08,0, 0,0,1,32'h00200113,32'h04};
    tbl[8]  = '{0,0,0,0,32'h0,32'h0,1,         1,0,1,32'h00300193,32'h08};
    tbl[9]  = '{0,0,0,0,32'h0,32'h0,1,         1,0,0,32'h0,32'h0};
    tbl[10] = '{0,0,0,1,WFI,32'h08,1,          0,1,0,32'h0,32'h0};
    tbl[11] = '{0,0,0,1,32'h00000013,32'h0c,1, 0,1,0,32'h0,32'h0};
    tbl[12] = '{0,0,1,0,32'h0,32'h0,1,         1,0,0,32'h0,32'h0};
    tbl[13] = '{0,0,0,1,32'h00400213,32'h10,0, 1,0,1,32'h00400213,32'h10};
    tbl[14] = '{0,0,0,1,32'h00500293,32'h14,0, 0,0,1,32'h00400213,32'h10};
    tbl[15] = '{0,1,0,1,32'h00600313,32'h18,1, 1,0,0,32'h0,32'h0};
    tbl[16] = '{0,0,0,1,32'h00700393,32'h40,0, 1,0,1,32'h00700393,32'h40};
    tbl[17] = '{0,1,0,1,32'h00800413,32'h44,1, 1,0,0,32'h0,32'h0};
    tbl[18] = '{0,0,0,1,32'h00900493,32'h48,0, 1,0,1,32'h00900493,32'h48};
    tbl[19] = '{0,0,0,1,WFI,32'h4c,0,          0,1,1,32'h00900493,32'h48};
    tbl[20] = '{1,0,0,0,32'h0,32'h0,0,         1,0,0,32'h0,32'h0};
    tbl[21] = '{0,0,1,1,WFI,32'h50,0,          0,1,0,32'h0,32'h0};
    tbl[22] = '{0,0,0,0,32'h0,32'h0,1,         0,1,0,32'h0,32'h0};
    tbl[23] = '{0,0,1,0,32'h0,32'h0,0,         1,0,0,32'h0,32'h0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: inputs held across one edge, outputs compared just after it.
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].start, tbl[i].br, tbl[i].wake, tbl[i].vld, tbl[i].ins, tbl[i].pc, tbl[i].drdy);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_wfi, tbl[i].e_vld, tbl[i].e_ins, tbl[i].e_pc);
    end

    // Async reset with one entry held while asleep: outputs must clear before any edge.
    drive(0, 0, 0, 1, 32'h00a00513, 32'h80, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1, WFI, 32'h84, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk_all("pre_arst", 1'b0, 1'b1, 1'b1, 32'h00a00513, 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("arst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random run against a queue model of the buffer.
    q.delete();
    m_wfi = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic m_rdy, flush, acc, popd;
      logic [31:0] hi, hp;
      hi = (q.size() != 0) ? q[0].ins : 32'h0;
      hp = (q.size() != 0) ? q[0].pc  : 32'h0;
      m_rdy = !m_wfi && (q.size() < DEPTH);
      chk_all("rand", m_rdy, m_wfi, q.size() != 0, hi, hp);

      drive($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? WFI : $urandom, $urandom, $urandom_range(0, 1) == 1);

      flush = start_vld | alu_ifu_br_vld;
      acc   = ifu_idu_vld && m_rdy && !flush;
      popd  = (q.size() != 0) && idu_dec_rdy && !flush;
      if (flush) begin
        q.delete();
        m_wfi = 1'b0;
      end else begin
        if (popd) void'(q.pop_front());
        if (acc && ifu_idu_ins != WFI) q.push_back('{ifu_idu_ins, ifu_idu_pc});
        if (m_wfi && wake_vld) m_wfi = 1'b0;
        else if (acc && ifu_idu_ins == WFI) m_wfi = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idu_ins_rx.md
Name: idu_ins_rx

Overview:
- Receive end of the IFU->IDU instruction interface, at the front of the decode stage.
- Accepts `ifu_idu_vld`/`ins`/`pc` beats under an `idu_ifu_rdy` handshake and buffers them in a small FIFO.
- Splits RV32 fields for the decoder and detects WFI, driving `idu_ifu_wfi` back to the fetch unit.
- Flushes on branch redirect or start, and sleeps in a WFI state until woken.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.
- PTR_W, 1, log2(DEPTH).
- WFI_ENC, 32'h10500073, instruction encoding recognised as WFI.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start_vld  in  1  core start; flushes FIFO and clears WFI
- alu_ifu_br_vld  in  1  branch redirect; flushes FIFO and clears WFI
- wake_vld  in  1  WFI wake event (interrupt pending)
- ifu_idu_vld  in  1  fetch beat valid
- ifu_idu_ins  in  32  fetched instruction
- ifu_idu_pc  in  32  PC of fetched instruction
- idu_ifu_rdy  out  1  IDU can accept a beat
- idu_ifu_wfi  out  1  IDU is in WFI; fetch must stop re-validating
- idu_dec_vld  out  1  head entry valid to decoder
- idu_dec_rdy  in  1  decoder consumes head
- idu_dec_ins  out  32  head instruction
- idu_dec_pc  out  32  head PC
- idu_dec_opcode  out  7  ins[6:0]
- idu_dec_rd  out  5  ins[11:7]
- idu_dec_funct3  out  3  ins[14:12]
- idu_dec_rs1  out  5  ins[19:15]
- idu_dec_rs2  out  5  ins[24:20]
- idu_dec_funct7  out  7  ins[31:25]

Behaviour:
- Clocking and reset: a single clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values:
  - wr_ptr, rd_ptr, count all 0.
  - State RUN; `idu_ifu_wfi`=0; `idu_dec_vld`=0.
  - `idu_ifu_rdy`=1.
  - FIFO data storage is not reset.
- Flush:
  - flush = `start_vld` | `alu_ifu_br_vld`.
  - Next edge: count=0, both pointers=0, state=RUN.
  - A beat presented in the flush cycle is discarded.
  - A decoder pop in the flush cycle is ignored.
- Accept:
  - acc = `ifu_idu_vld` & `idu_ifu_rdy` & ~flush.
  - `idu_ifu_rdy` = (state==RUN) & (count != DEPTH). It is combinational from registered state only; there is no path from `ifu_idu_vld`.
- Push/pop:
  - push = acc & (`ifu_idu_ins` != WFI_ENC).
  - pop = `idu_dec_vld` & `idu_dec_rdy` & ~flush.
  - Simultaneous push and pop when full is impossible, because rdy=0 when full.
  - Push and pop together when 0 < count < DEPTH: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
- Decoder output:
  - `idu_dec_vld` = (count != 0).
  - `idu_dec_ins`/`pc` = entry[rd_ptr], with field outputs sliced from it.
  - Latency: a beat accepted at edge N is visible on the idu_dec_* outputs in cycle N+1.
  - Head data is stable while `idu_dec_vld` & ~`idu_dec_rdy`.
- WFI:
  - An accepted beat equal to WFI_ENC is consumed and not pushed.
  - State RUN -> WFI at the next edge.
  - In WFI: `idu_ifu_wfi`=1 (registered) and `idu_ifu_rdy`=0.
  - Entries already in the FIFO keep draining to the decoder.
  - WFI -> RUN on `wake_vld` or flush; `idu_ifu_wfi` deasserts at that edge.
  - A wake in the same cycle as WFI acceptance still enters WFI; the wake is not held.
  - A second beat cannot be accepted while in WFI.
- Priority: flush > wake > WFI acceptance.
- Reset asserted mid-operation returns to reset values immediately; any buffered entries are lost.

Test Plan:
- Streaming: after reset, present ins 32'h00500093/pc 0, then 32'h00a00113/pc 4, with `idu_dec_rdy`=1. Required: `idu_dec_vld` high from cycle 1; opcode 7'h13, rd 1 then rd 2; pc 0 then 4; `idu_ifu_rdy` stays 1.
- Backpressure: hold `idu_dec_rdy`=0 and present 3 beats. Required: `idu_ifu_rdy`=0 after 2 accepts; the 3rd beat is held by the source. Then release `idu_dec_rdy`. Required: order pc 0,4,8 with no loss or duplication, and the head stays stable while stalled.
- WFI: present 32'h10500073 at pc 8. Required: not forwarded; `idu_ifu_wfi`=1 next cycle; `idu_ifu_rdy`=0. Pulse `wake_vld`. Required: `idu_ifu_wfi`=0 and `idu_ifu_rdy`=1 the cycle after.
- Branch flush: with 2 entries buffered and a beat in flight, assert `alu_ifu_br_vld`. Required: next cycle count=0 and `idu_dec_vld`=0; the first beat after the flush (pc 12'h040) appears as head.
- Start during WFI: enter WFI, then assert `start_vld`. Required: `idu_ifu_wfi` clears and FIFO empties at the next edge.
- Async reset mid-stream: drop `rst_n` with 1 entry held. Required: `idu_dec_vld`, `idu_ifu_wfi`=0 and `idu_ifu_rdy`=1 immediately, without waiting for a clock edge.
